hs32_regfile_nr2w: RTL and testbench
====================================

# hs32_regfile_nr2w

Parametrised banked register file for the HS32 core: two banks (full bank 0, shadow bank 1), N combinational read ports with per-port bank select, two write ports with per-half enables, optional same-cycle write-to-read bypass, and a sequenced clear engine that zeroes the arrays after reset or on request. Sits between decode (read addresses) and writeback (write ports) and replaces the fixed 4-read/1-write file.

## Interface
- XLEN, 32, data width; even, ≥16; halves are [XLEN-1:XLEN/2] hi and [XLEN/2-1:0] lo
- B0_DEPTH, 16, bank 0 entries; power of two
- B1_DEPTH, 8, bank 1 entries; power of two, ≤ B0_DEPTH
- NREAD, 4, read port count, 1..8
- BYPASS, 1, 1: reads forward same-cycle write data
- CLEAR_ON_RESET, 1, 1: clear sequence runs after reset release
- AW (localparam) = $clog2(B0_DEPTH); B1W = $clog2(B1_DEPTH)
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; one clock; asynchronous and active-low
- clear_i  in  1  pulse: start clear sequence
- busy_o  out  1  clear sequence in progress
- wp_addr_i  in  2×AW  write address, port 0/1
- wp_data_i  in  2×XLEN  write data
- wp_we_i  in  2×2  per port: [0] bank 0 enable, [1] bank 1 enable
- wp_hwe_i  in  2×2  per port: [1] hi-half enable, [0] lo-half enable
- rp_bank_i  in  NREAD  per read port bank select (0: bank 0, 1: bank 1)
- rp_addr_i  in  NREAD×AW  read address
- rp_data_o  out  NREAD×XLEN  read data

## Operation
- Bank 1 indexed by addr[B1W-1:0]; upper bits ignored (aliasing is intended).
- A half of entry (bank, idx) is written at posedge when port's bank enable and half enable are set. Both bank enables may be set: both banks written.
- Write conflict: both ports target the same bank, index and half → port 0 wins for that half; non-overlapping halves from each port both commit.
- Reads combinational. BYPASS=1: each half of rp_data_o takes the winning same-cycle write data for that (bank, idx, half), else array value. BYPASS=0: array value only.
- Clear FSM states: IDLE, CLEAR. Index counter cnt, AW bits.
  - reset_n low: state = CLEAR if CLEAR_ON_RESET else IDLE; cnt = 0. Arrays are not async-reset.
  - CLEAR: each cycle zero bank0[cnt] and, if cnt < B1_DEPTH, bank1[cnt]; cnt++. At cnt = B0_DEPTH-1 → IDLE after that cycle's write.
  - IDLE + clear_i → CLEAR, cnt = 0. clear_i during CLEAR ignored (no restart).
- busy_o = (state == CLEAR). While busy: all write-port writes dropped; rp_data_o forced 0 (bypass suppressed).
- reset_n asserted mid-clear: sequence restarts from 0 on release.

## Timing
- Reset values: busy_o = CLEAR_ON_RESET; rp_data_o = 0 while busy, else array value (undefined after reset when CLEAR_ON_RESET=0).
- Write latency 1 cycle (visible at next edge); 0 cycles with BYPASS=1.
- Clear takes exactly B0_DEPTH cycles; busy_o falls on the edge after the last index is cleared; a write issued that same following cycle commits.
- clear_i sampled in IDLE → busy_o high from next edge.

## Structure
- hs32_regfile_pkg: clear FSM state enum, half-enable bit indices (HWE_LO=0, HWE_HI=1), bank-enable indices.
- Sub-module hs32_regfile_clrseq: FSM, counter, busy_o, clear strobe/index outputs; parent owns arrays, write arbitration, bypass.

## Test plan
- Reset release with defaults → busy_o high 16 cycles, writes in that window dropped, all reads 0; busy_o low at cycle 16.
- Port 0 writes bank 0 idx 5 = 0xDEADBEEF, both halves → rp0 bank 0 addr 5 reads 0xDEADBEEF same cycle (BYPASS=1), next cycle (BYPASS=0).
- Port 0 hi-only 0x1234xxxx and port 1 lo-only 0xxxxx5678 to bank 1 idx 3, same cycle → reads 0x12345678.
- Both ports full write bank 0 idx 2, data 0xAAAAAAAA / 0x55555555 → 0xAAAAAAAA stored.
- Bank 1 write addr 0xB (B1_DEPTH=8) → read bank 1 addr 3 returns data; bank 0 addr 0xB unchanged.
- clear_i mid-operation, then reset_n pulsed at clear cycle 7 → sequence restarts, busy_o high 16 cycles after release; clear_i during busy has no effect.

Source files
------------

// File: rtl/hs32_regfile_pkg.sv
// Shared types and constants for the HS32 banked register file.
// Provides the clear-sequencer state enum and the bit positions used
// inside the per-port bank-enable and half-enable vectors.
package hs32_regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Half-enable bit positions within wp_hwe_i[p]
  localparam int unsigned HWE_LO = 0;
  localparam int unsigned HWE_HI = 1;

  // Bank-enable bit positions within wp_we_i[p]
  localparam int unsigned WE_B0 = 0;
  localparam int unsigned WE_B1 = 1;

  localparam int unsigned NWP   = 2;  // write ports
  localparam int unsigned NHALF = 2;  // data halves per entry

endpackage

// File: rtl/hs32_regfile_nr2w_if.sv
// Read/write port bundle of the HS32 banked register file.
// master: decode/writeback side (drives addresses, enables, write data)
// slave : register file (returns read data)
//   wp_addr_i  2 x AW     write address per write port
//   wp_data_i  2 x XLEN   write data per write port
//   wp_we_i    2 x 2      bank enables   ([0] bank 0, [1] bank 1)
//   wp_hwe_i   2 x 2      half enables   ([1] hi, [0] lo)
//   rp_bank_i  NREAD      bank select per read port
//   rp_addr_i  NREAD x AW read address per read port
//   rp_data_o  NREAD x XLEN read data per read port
interface hs32_regfile_nr2w_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned NREAD = 4
) ();

  logic [1:0][AW-1:0]         wp_addr_i;
  logic [1:0][XLEN-1:0]       wp_data_i;
  logic [1:0][1:0]            wp_we_i;
  logic [1:0][1:0]            wp_hwe_i;
  logic [NREAD-1:0]           rp_bank_i;
  logic [NREAD-1:0][AW-1:0]   rp_addr_i;
  logic [NREAD-1:0][XLEN-1:0] rp_data_o;

  modport master (
    output wp_addr_i, wp_data_i, wp_we_i, wp_hwe_i, rp_bank_i, rp_addr_i,
    input  rp_data_o
  );

  modport slave (
    input  wp_addr_i, wp_data_i, wp_we_i, wp_hwe_i, rp_bank_i, rp_addr_i,
    output rp_data_o
  );

endinterface

// File: rtl/hs32_regfile_clrseq.sv
// Clear sequencer: walks an index from 0 to DEPTH-1, one entry per cycle,
// after reset release (optional) or on a clear_i pulse while idle.
//   clk, reset_n   clock, async active-low reset
//   clear_i        start request, ignored while a sequence is running
//   busy_o         sequence in progress
//   clr_c          zero bank 0 at clr_idx this cycle
//   clr_b1_c       also zero bank 1 at clr_idx this cycle (clr_idx < B1_DEPTH)
//   clr_idx        index being cleared
module hs32_regfile_clrseq
  import hs32_regfile_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned B1_DEPTH       = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  output logic          busy_o,
  output logic          clr_c,
  output logic          clr_b1_c,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: requests only accepted from IDLE, so a running clear never restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o   = (state_q == ST_CLEAR);
  assign clr_c    = busy_o;
  assign clr_b1_c = busy_o && (32'(cnt_q) < B1_DEPTH);
  assign clr_idx  = cnt_q;

endmodule

// File: rtl/hs32_regfile_nr2w.sv
// HS32 banked register file: full bank 0, aliased shadow bank 1,
// NREAD combinational read ports, two half-enabled write ports with
// port 0 priority, optional same-cycle write-to-read forwarding, and a
// clear sequencer that zeroes both arrays.
//   clk, reset_n   clock, async active-low reset (sequencer only)
//   clear_i        pulse: start clear sequence
//   busy_o         clear in progress; writes dropped, reads return 0
//   rf             port bundle (slave side)
module hs32_regfile_nr2w
  import hs32_regfile_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned B0_DEPTH       = 16,
  parameter int unsigned B1_DEPTH       = 8,
  parameter int unsigned NREAD          = 4,
  parameter bit          BYPASS         = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_i,
  output logic                busy_o,
  hs32_regfile_nr2w_if.slave  rf
);

  localparam int unsigned AW   = $clog2(B0_DEPTH);
  localparam int unsigned B1W  = $clog2(B1_DEPTH);
  localparam int unsigned HALF = XLEN / 2;

  typedef logic [NHALF-1:0][HALF-1:0] entry_t;

  entry_t bank0 [B0_DEPTH];
  entry_t bank1 [B1_DEPTH];

  logic          clr_c;
  logic          clr_b1_c;
  logic [AW-1:0] clr_idx;

  logic [NWP-1:0][NHALF-1:0]           wen_b0;
  logic [NWP-1:0][NHALF-1:0]           wen_b1;
  logic [NWP-1:0][NHALF-1:0][HALF-1:0] wdata;
  logic [NWP-1:0][B1W-1:0]             widx1;
  logic [NREAD-1:0][NHALF-1:0][HALF-1:0] rdata;

  hs32_regfile_clrseq #(
    .DEPTH          (B0_DEPTH),
    .B1_DEPTH       (B1_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clrseq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (clear_i),
    .busy_o   (busy_o),
    .clr_c    (clr_c),
    .clr_b1_c (clr_b1_c),
    .clr_idx  (clr_idx)
  );

  assign wdata = rf.wp_data_i;

  // Per port/bank/half write enables, all dropped while clearing
  always_comb begin
    wen_b0 = '0;
    wen_b1 = '0;
    widx1  = '0;
    for (int p = 0; p < 2; p++) begin
      widx1[p] = rf.wp_addr_i[p][B1W-1:0];
      for (int h = 0; h < 2; h++) begin
        wen_b0[p][h] = !busy_o && rf.wp_we_i[p][WE_B0] && rf.wp_hwe_i[p][h];
        wen_b1[p][h] = !busy_o && rf.wp_we_i[p][WE_B1] && rf.wp_hwe_i[p][h];
      end
    end
  end

  // Array update: port 1 applied first so port 0 overwrites on a shared half
  always_ff @(posedge clk) begin
    if (clr_c) begin
      bank0[clr_idx] <= '0;
      if (clr_b1_c) begin
        bank1[clr_idx[B1W-1:0]] <= '0;
      end
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int h = 0; h < 2; h++) begin
          if (wen_b0[p][h]) begin
            bank0[rf.wp_addr_i[p]][h] <= wdata[p][h];
          end
          if (wen_b1[p][h]) begin
            bank1[widx1[p]][h] <= wdata[p][h];
          end
        end
      end
    end
  end

  // Read mux with per-half forwarding of the winning write
  always_comb begin
    rdata = '0;
    for (int r = 0; r < int'(NREAD); r++) begin
      for (int h = 0; h < 2; h++) begin
        if (rf.rp_bank_i[r]) begin
          rdata[r][h] = bank1[rf.rp_addr_i[r][B1W-1:0]][h];
        end else begin
          rdata[r][h] = bank0[rf.rp_addr_i[r]][h];
        end
        if (BYPASS) begin
          for (int p = 1; p >= 0; p--) begin
            if (rf.rp_bank_i[r]) begin
              if (wen_b1[p][h] && (widx1[p] == rf.rp_addr_i[r][B1W-1:0])) begin
                rdata[r][h] = wdata[p][h];
              end
            end else begin
              if (wen_b0[p][h] && (rf.wp_addr_i[p] == rf.rp_addr_i[r])) begin
                rdata[r][h] = wdata[p][h];
              end
            end
          end
        end
        if (busy_o) begin
          rdata[r][h] = '0;
        end
      end
    end
  end

  assign rf.rp_data_o = rdata;

endmodule

// File: tb/tb_hs32_regfile_nr2w.sv
// Bench for hs32_regfile_nr2w: a forwarding instance and a non-forwarding
// instance see identical stimulus; expected read data and busy values are
// queued when a cycle is driven and compared just after the inputs settle.
module tb_hs32_regfile_nr2w;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned B0    = 16;
  localparam int unsigned B1    = 8;
  localparam int unsigned NREAD = 4;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic clear_i;
  logic busy0, busy1;

  always #5 clk = ~clk;

  hs32_regfile_nr2w_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) rf0 ();
  hs32_regfile_nr2w_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) rf1 ();

  assign rf1.wp_addr_i = rf0.wp_addr_i;
  assign rf1.wp_data_i = rf0.wp_data_i;
  assign rf1.wp_we_i   = rf0.wp_we_i;
  assign rf1.wp_hwe_i  = rf0.wp_hwe_i;
  assign rf1.rp_bank_i = rf0.rp_bank_i;
  assign rf1.rp_addr_i = rf0.rp_addr_i;

  hs32_regfile_nr2w #(
    .XLEN(XLEN), .B0_DEPTH(B0), .B1_DEPTH(B1), .NREAD(NREAD),
    .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .busy_o(busy0), .rf(rf0.slave)
  );

  hs32_regfile_nr2w #(
    .XLEN(XLEN), .B0_DEPTH(B0), .B1_DEPTH(B1), .NREAD(NREAD),
    .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .busy_o(busy1), .rf(rf1.slave)
  );

  // port 0..3 = rp_data_o[port], port 4 = busy_o
  typedef struct packed {
    logic [127:0] tag;
    logic         dut;
    logic [2:0]   port;
    logic [31:0]  exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input logic [127:0] tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %0s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [127:0] tag, input logic dut, input int port, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.port = 3'(port);
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic push2(input logic [127:0] tag, input int port, input logic [31:0] exp);
    push(tag, 1'b0, port, exp);
    push(tag, 1'b1, port, exp);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port == 3'd4) got = e.dut ? 32'(busy1) : 32'(busy0);
      else                got = e.dut ? rf1.rp_data_o[e.port[1:0]] : rf0.rp_data_o[e.port[1:0]];
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic idle_in();
    rf0.wp_addr_i = '0;
    rf0.wp_data_i = '0;
    rf0.wp_we_i   = '0;
    rf0.wp_hwe_i  = '0;
    rf0.rp_bank_i = '0;
    rf0.rp_addr_i = '0;
    clear_i       = 1'b0;
  endtask

  task automatic wr(input int p, input logic [1:0] we, input logic [1:0] hwe,
                    input logic [3:0] addr, input logic [31:0] d);
    rf0.wp_we_i[p]   = we;
    rf0.wp_hwe_i[p]  = hwe;
    rf0.wp_addr_i[p] = addr;
    rf0.wp_data_i[p] = d;
  endtask

  task automatic rd(input int r, input logic bank, input logic [3:0] addr);
    rf0.rp_bank_i[r] = bank;
    rf0.rp_addr_i[r] = addr;
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    push2("rst_busy", 4, 32'd1);
    push2("rst_rd", 0, 32'd0);
    drain();
    reset_n = 1'b1;

    // Post-reset clear: writes to the read address must neither land nor forward
    for (int k = 0; k < 16; k++) begin
      idle_in();
      wr(0, 2'b11, 2'b11, 4'(k), 32'hFFFF_FFFF);
      rd(0, 1'b0, 4'(k));
      rd(1, 1'b1, 4'(k));
      push2("clr_busy", 4, 32'd1);
      push2("clr_rd_b0", 0, 32'd0);
      push2("clr_rd_b1", 1, 32'd0);
      drain();
      nxt();
    end

    // First idle cycle: write commits, forwarded only by the bypass instance
    idle_in();
    wr(0, 2'b01, 2'b11, 4'd5, 32'hDEAD_BEEF);
    rd(0, 1'b0, 4'd5); rd(1, 1'b0, 4'd3); rd(2, 1'b0, 4'd15); rd(3, 1'b1, 4'd7);
    push2("idle_busy", 4, 32'd0);
    push("byp_full", 1'b0, 0, 32'hDEAD_BEEF);
    push("nobyp_full", 1'b1, 0, 32'd0);
    push2("junk_b0_3", 1, 32'd0);
    push2("junk_b0_15", 2, 32'd0);
    push2("junk_b1_7", 3, 32'd0);
    drain(); nxt();

    idle_in();
    wr(0, 2'b10, 2'b10, 4'd3, 32'h1234_ABCD);
    wr(1, 2'b10, 2'b01, 4'd3, 32'h9999_5678);
    rd(0, 1'b0, 4'd5); rd(1, 1'b1, 4'd3);
    push2("wr_lat", 0, 32'hDEAD_BEEF);
    push("byp_merge", 1'b0, 1, 32'h1234_5678);
    push("nobyp_merge", 1'b1, 1, 32'd0);
    drain(); nxt();

    idle_in();
    wr(0, 2'b01, 2'b11, 4'd2, 32'hAAAA_AAAA);
    wr(1, 2'b01, 2'b11, 4'd2, 32'h5555_5555);
    rd(1, 1'b1, 4'd3); rd(2, 1'b0, 4'd2);
    push2("merge", 1, 32'h1234_5678);
    push("byp_conf", 1'b0, 2, 32'hAAAA_AAAA);
    push("nobyp_conf", 1'b1, 2, 32'd0);
    drain(); nxt();

    idle_in();
    wr(0, 2'b10, 2'b11, 4'hB, 32'hCAFE_F00D);
    rd(2, 1'b0, 4'd2); rd(3, 1'b1, 4'd3); rd(0, 1'b0, 4'hB);
    push2("conf", 2, 32'hAAAA_AAAA);
    push("byp_alias", 1'b0, 3, 32'hCAFE_F00D);
    push("nobyp_alias", 1'b1, 3, 32'h1234_5678);
    push2("alias_b0_now", 0, 32'd0);
    drain(); nxt();

    idle_in();
    wr(1, 2'b11, 2'b11, 4'd7, 32'h0BAD_C0DE);
    rd(3, 1'b1, 4'd3); rd(0, 1'b0, 4'hB); rd(1, 1'b0, 4'd5); rd(2, 1'b1, 4'd7);
    push2("alias", 3, 32'hCAFE_F00D);
    push2("alias_b0", 0, 32'd0);
    push2("keep5", 1, 32'hDEAD_BEEF);
    push("byp_both", 1'b0, 2, 32'h0BAD_C0DE);
    push("nobyp_both", 1'b1, 2, 32'd0);
    drain(); nxt();

    idle_in();
    wr(0, 2'b01, 2'b01, 4'd5, 32'h0000_1111);
    rd(0, 1'b0, 4'd7); rd(2, 1'b1, 4'd7); rd(1, 1'b0, 4'd5);
    push2("both_b0", 0, 32'h0BAD_C0DE);
    push2("both_b1", 2, 32'h0BAD_C0DE);
    push("byp_lo", 1'b0, 1, 32'hDEAD_1111);
    push("nobyp_lo", 1'b1, 1, 32'hDEAD_BEEF);
    drain(); nxt();

    idle_in();
    wr(0, 2'b01, 2'b10, 4'd9, 32'h7777_AAAA);
    wr(1, 2'b01, 2'b11, 4'd9, 32'h8888_9999);
    rd(1, 1'b0, 4'd5); rd(2, 1'b0, 4'd9);
    push2("lo_only", 1, 32'hDEAD_1111);
    push("byp_part", 1'b0, 2, 32'h7777_9999);
    push("nobyp_part", 1'b1, 2, 32'd0);
    drain(); nxt();

    // Clear request while idle: busy rises on the next edge
    idle_in();
    clear_i = 1'b1;
    rd(2, 1'b0, 4'd9);
    push2("part_conf", 2, 32'h7777_9999);
    push2("pre_clr_busy", 4, 32'd0);
    drain(); nxt();

    for (int k = 0; k < 7; k++) begin
      idle_in();
      if (k == 3) clear_i = 1'b1;
      wr(0, 2'b01, 2'b11, 4'(k), 32'hFFFF_FFFF);
      rd(0, 1'b0, 4'(k)); rd(2, 1'b0, 4'd9);
      push2("req_busy", 4, 32'd1);
      push2("req_rd_byp", 0, 32'd0);
      push2("req_rd9", 2, 32'd0);
      drain(); nxt();
    end

    // Reset in the middle of the sequence: restart from index 0
    idle_in();
    reset_n = 1'b0;
    push2("mid_rst_busy", 4, 32'd1);
    drain(); nxt();
    reset_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      idle_in();
      if (k == 10 || k == 15) clear_i = 1'b1;
      push2("restart_busy", 4, 32'd1);
      drain(); nxt();
    end

    // Sequence done: prior contents gone, a write in this cycle commits
    idle_in();
    wr(0, 2'b01, 2'b11, 4'd1, 32'h1357_9BDF);
    rd(0, 1'b0, 4'd9); rd(1, 1'b0, 4'd5); rd(2, 1'b1, 4'd3); rd(3, 1'b0, 4'd2);
    push2("done_busy", 4, 32'd0);
    push2("cleared9", 0, 32'd0);
    push2("cleared5", 1, 32'd0);
    push2("cleared_b1", 2, 32'd0);
    push2("cleared2", 3, 32'd0);
    drain(); nxt();

    idle_in();
    rd(0, 1'b0, 4'd1);
    push2("post_clr_wr", 0, 32'h1357_9BDF);
    push2("still_idle", 4, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
